// File: rtl/mult_unit_if.sv
// mult_unit_if -- request/response bundle between the execute stage and
// the iterative multiplier.
//   mult    : request valid (multiply-class instruction in decode/execute)
//   op      : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b    : rs1 / rs2 operands
//   advance : decode/execute register enable (instruction leaves execute)
//   flush   : decode/execute flush, aborts any operation
//   ready   : result valid
//   result  : low word for MUL, high word for the MULH* variants
`timescale 1ns/1ps
interface mult_unit_if;
    logic        mult;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        advance;
    logic        flush;
    logic        ready;
    logic [31:0] result;

    modport master (
        output mult, op, a, b, advance, flush,
        input  ready, result
    );

    modport slave (
        input  mult, op, a, b, advance, flush,
        output ready, result
    );
endinterface

// File: rtl/mult_unit.sv
// mult_unit -- iterative shift-and-add 32x32 multiplier for the execute
// stage (MUL / MULH / MULHSU / MULHU).
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mult_unit_if.slave (mult, op, a, b, advance, flush -> ready, result)
// Operands are reduced to unsigned magnitudes on capture; the product sign
// is re-applied in the last busy cycle. Base latency is 33 cycles from the
// capture cycle to ready.
// Optional feature: define MULT_EARLY_TERM_EN to leave BUSY as soon as the
// shifted multiplier register becomes zero.
`timescale 1ns/1ps
module mult_unit (
    input  logic        clk,
    input  logic        rst,
    mult_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_op;
    logic [31:0] r_mlr;
    logic [63:0] r_mcand;
    logic [63:0] r_acc;
    logic [4:0]  r_count;
    logic        r_sign;
    logic        r_ready;
    logic [31:0] r_result;

    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_acc_sum;
    logic [63:0] w_acc_final;
    logic [31:0] w_mlr_shift;
    logic        w_last;
    logic        w_capture;
    logic        w_step;
    logic        w_finish;

    // MULH: both signed; MULHSU: only rs1 signed; MUL low word is
    // sign-independent so it takes the unsigned path.
    assign w_a_signed = (bus.op == 2'b01) || (bus.op == 2'b10);
    assign w_b_signed = (bus.op == 2'b01);
    assign w_a_neg    = w_a_signed & bus.a[31];
    assign w_b_neg    = w_b_signed & bus.b[31];
    // 32-bit unsigned magnitude: 0x8000_0000 negates to itself = 2^31.
    assign w_a_mag    = w_a_neg ? (~bus.a + 32'd1) : bus.a;
    assign w_b_mag    = w_b_neg ? (~bus.b + 32'd1) : bus.b;

    assign w_acc_sum   = r_acc + (r_mlr[0] ? r_mcand : '0);
    assign w_acc_final = r_sign ? (~w_acc_sum + 64'd1) : w_acc_sum;
    assign w_mlr_shift = r_mlr >> 1;

`ifdef MULT_EARLY_TERM_EN
    assign w_last = (r_count == 5'd31) || (w_mlr_shift == '0);
`else
    assign w_last = (r_count == 5'd31);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush wins over both mult (in IDLE) and advance (in DONE).
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mult) begin
                        w_capture    = 1'b1;
                        w_state_next = S_BUSY;
                    end
                end
                S_BUSY: begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_finish     = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.advance) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_mlr    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            // ready is a registered copy of "next state is DONE".
            r_ready <= (w_state_next == S_DONE);
            if (w_capture) begin
                r_op    <= bus.op;
                r_mlr   <= w_b_mag;
                r_mcand <= {32'd0, w_a_mag};
                r_acc   <= '0;
                r_count <= '0;
                r_sign  <= w_a_neg ^ w_b_neg;
            end else if (w_step) begin
                r_acc   <= w_finish ? w_acc_final : w_acc_sum;
                r_mlr   <= w_mlr_shift;
                r_mcand <= r_mcand << 1;
                r_count <= r_count + 5'd1;
            end
            if (w_finish) begin
                r_result <= (r_op == 2'b00) ? w_acc_final[31:0] : w_acc_final[63:32];
            end
        end
    end

    assign bus.ready  = r_ready;
    assign bus.result = r_result;

endmodule
